// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Optional early-exit behaviour is enabled by defining MUL_EARLY_EXIT_EN.
package shift_add_multiplier_pkg;

    localparam int XLEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder of parameterizable width.
// The carry is chained through a loop variable to keep it one flat cone.
module ripple_carry_adder #(
    parameter int xlen = 32
) (
    input  logic [xlen-1:0] a,
    input  logic [xlen-1:0] b,
    input  logic            carry_in,
    output logic [xlen-1:0] sum,
    output logic            carry_out
);

    logic c;

    always_comb begin
        c   = carry_in;
        sum = '0;
        for (int i = 0; i < xlen; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned XLEN x XLEN multiplier, one partial product per cycle.
// Define MUL_EARLY_EXIT_EN to leave RUN once the remaining multiplier is 0.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int PW = 2 * XLEN;
    localparam int CW = cnt_width(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    mul_state_e state_q, state_d;

    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic [PW-1:0]   sum;
    logic            adder_cout_unused;
    logic            last_iter;

    // The product always fits in PW bits, so the carry out never sets.
    ripple_carry_adder #(
        .xlen(PW)
    ) u_adder (
        .a        (acc_q),
        .b        (mcand_q),
        .carry_in (1'b0),
        .sum      (sum),
        .carry_out(adder_cout_unused)
    );

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_LAST)
                     || (mplier_q[XLEN-1:1] == '0);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            (state_q == RUN): begin
                acc_d    = mplier_q[0] ? sum : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Capture the final sum so product is valid with done.
                if (last_iter) begin
                    state_d   = DONE;
                    product_d = acc_d;
                end
            end
            (state_q == DONE): begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector and random bench for shift_add_multiplier (XLEN=16).
// Expected RUN length follows MUL_EARLY_EXIT_EN when it is defined.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int errors;
    int cyc;
    int done_cyc;
    int prev_done;
    bit have_prev;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[12];

    shift_add_multiplier #(
        .XLEN(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int exp_run(input logic [15:0] y);
`ifdef MUL_EARLY_EXIT_EN
        int r = 1;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) r = i + 1;
        end
        return r;
`else
        return 16;
`endif
    endfunction

    // Present an operation for one edge, then scramble the operands.
    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic wait_done(input int poke_start,
                             output int run_n,
                             output logic [31:0] p,
                             output bit timed_out);
        run_n     = 0;
        p         = 'x;
        timed_out = 1'b1;
        for (int g = 0; g < 64; g++) begin
            if (done) begin
                timed_out = 1'b0;
                p         = product;
                done_cyc  = cyc;
                break;
            end
            if (busy) run_n++;
            start = busy && (run_n == poke_start);
            if (start) begin
                a = 16'd7;
                b = 16'd7;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic do_mul(input logic [15:0] x,
                          input logic [15:0] y,
                          input logic [31:0] expp,
                          input int poke);
        int          run_n;
        logic [31:0] p;
        bit          to;
        issue(x, y);
        wait_done(poke, run_n, p, to);
        check("timeout", 64'(to), 64'(0));
        check("product", 64'(p), 64'(expp));
        check("run_cycles", 64'(run_n), 64'(exp_run(y)));
`ifndef MUL_EARLY_EXIT_EN
        if (have_prev) begin
            check("spacing", 64'(done_cyc - prev_done >= 18), 64'(1));
        end
`endif
        prev_done = done_cyc;
        have_prev = 1'b1;
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'(0));
        check("product_hold", 64'(product), 64'(expp));
    endtask

    task automatic quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done || busy) seen++;
            @(posedge clk);
            #1;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [15:0] x;
        logic [15:0] y;
        int          k;

        checks    = 0;
        errors    = 0;
        have_prev = 1'b0;
        prev_done = 0;
        done_cyc  = 0;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2]  = '{16'h1234, 16'h0000, 32'h0000_0000};
        vecs[3]  = '{16'h0000, 16'hFFFF, 32'h0000_0000};
        vecs[4]  = '{16'h0001, 16'h0001, 32'h0000_0001};
        vecs[5]  = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[6]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[7]  = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vecs[8]  = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[9]  = '{16'hABCD, 16'h1000, 32'h0ABC_D000};
        vecs[10] = '{16'h0002, 16'h8001, 32'h0001_0002};
        vecs[11] = '{16'h000A, 16'h000A, 32'h0000_0064};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].p, -1);
        end

        // A start raised mid-run must be dropped, not queued.
`ifdef MUL_EARLY_EXIT_EN
        k = 1;
`else
        k = 5;
`endif
        do_mul(16'd2, 16'd3, 32'd6, k);
        quiet("ignored_start", 25);
        check("ignored_product", 64'(product), 64'(6));
        do_mul(16'd7, 16'd7, 32'd49, -1);

        // Reset in the middle of a run discards it silently.
`ifdef MUL_EARLY_EXIT_EN
        k = 3;
`else
        k = 8;
`endif
        issue(16'd100, 16'd100);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        quiet("rst_no_done", 25);
        have_prev = 1'b0;
        do_mul(16'd10, 16'd10, 32'd100, -1);

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 8 == 0) y = y >> (i % 16);
            do_mul(x, y, 32'(x) * 32'(y), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
